sprite_layer_mux: RTL and testbench
===================================

# sprite_layer_mux

Parametrised sprite compositor for the VGA pixel path: takes NUM_SPRITES sprite generators' colour and visibility, selects the highest-priority enabled visible sprite per pixel, and drives one registered colour/visibility pair to the display stage. Adds frame-synchronous enable latching, per-sprite blink, selectable priority order and sprite-collision detection, none of which the two-sprite selector has. Sits between the sprite instances and the VGA colour output.

## Interface
- NUM_SPRITES, 4, number of sprite channels (2..8)
- COLOR_W, 24, colour width per channel
- BLINK_FRAMES, 16, frames per blink half-period (≥1)
- BG_COLOR, 24'h000000, colour driven when no sprite wins
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- sprite_rgb  in  NUM_SPRITES*COLOR_W  packed colours, sprite i at [i*COLOR_W +: COLOR_W]
- sprite_vis  in  NUM_SPRITES  per-sprite visibility at current pixel
- enable_mask  in  NUM_SPRITES  requested enabled sprites (shadowed)
- blink_mask  in  NUM_SPRITES  requested blinking sprites (shadowed)
- prio_rev  in  1  0: lowest index wins; 1: highest index wins (shadowed)
- visible  out  1  a sprite won this pixel
- rgb  out  COLOR_W  composited colour
- hit_id  out  $clog2(NUM_SPRITES)  index of winning sprite, 0 if none
- collision  out  1  ≥2 effective sprites visible at same pixel (per-pixel, registered)
- collision_frame  out  1  any collision during previous frame
- blink_phase  out  1  current blink phase

## Operation
- Shadow registers en_s, bl_s, rev_s load enable_mask, blink_mask, prio_rev on a clk edge where frame_start=1; otherwise hold. Mid-frame mask changes have no effect until next frame_start.
- Frame counter fc (0..BLINK_FRAMES-1) increments on each frame_start; on wrap to 0, blink_phase toggles.
- Effective visibility eff[i] = sprite_vis[i] & en_s[i] & ~(bl_s[i] & blink_phase).
- Winner: rev_s=0 → lowest i with eff[i]; rev_s=1 → highest i. If none: visible=0, rgb=BG_COLOR, hit_id=0.
- collision = popcount(eff) ≥ 2.
- Sticky flag coll_live sets on any collision cycle. On frame_start edge: collision_frame ← coll_live | current-cycle collision; coll_live ← 0.
- Reset: visible=0, rgb=0, hit_id=0, collision=0, collision_frame=0, blink_phase=0, fc=0, en_s=bl_s=0, rev_s=0, coll_live=0. With en_s=0 after reset, output is BG_COLOR from the first post-reset pixel until the first frame_start.

## Timing
- Latency: one clk from sprite_rgb/sprite_vis to visible/rgb/hit_id/collision (single output register stage).
- Pixel sampled in the frame_start cycle uses pre-edge shadow values, pre-edge blink_phase; new values apply from the following cycle.
- frame_start while rst=1: reset wins, nothing loads.
- Reset asserted mid-frame: outputs take reset values on that edge; collision history discarded.
- BLINK_FRAMES=1: blink_phase toggles every frame_start.
- All sprites blinking and blink_phase=1: output BG_COLOR, collision=0.
- Back-to-back frame_start pulses are legal; each counts as a frame.

## Test plan
- Reset then enable_mask=4'b0011, prio_rev=0, frame_start; sprite_vis=4'b0011, rgb0=24'hFF0000, rgb1=24'h00FF00 → next cycle visible=1, rgb=FF0000, hit_id=0, collision=1.
- Same pixel with prio_rev=1 latched at next frame_start → rgb=00FF00, hit_id=1; change prio_rev mid-frame → output unchanged until frame_start.
- sprite_vis=0 → visible=0, rgb=BG_COLOR, hit_id=0, one-cycle latency checked.
- blink_mask=4'b0001, BLINK_FRAMES=2: sprite 0 visible for 2 frames, hidden for 2 frames (blink_phase toggles every 2nd frame_start); sprite 1 shown behind it when hidden.
- Single collision pixel in frame N → collision_frame=1 after frame_start ending N; no collision in N+1 → collision_frame=0 after next frame_start; collision in the frame_start cycle itself counted.
- Assert rst mid-frame with collisions and blink_phase=1 → all outputs and blink_phase zero next cycle; BG_COLOR until first frame_start.

Source files
------------

// File: rtl/sprite_layer_mux.sv
// sprite_layer_mux: per-pixel sprite compositor for the VGA colour path.
// Picks the highest-priority enabled, visible sprite each pixel and drives a
// registered colour/visibility/id pair. Enable, blink and priority controls
// are shadowed and only take effect at frame_start, so a frame never changes
// its look half-way down the screen. Also reports per-pixel and per-frame
// sprite collisions and runs a frame-counted blink phase.
module sprite_layer_mux #(
   parameter int                 NUM_SPRITES  = 4,
   parameter int                 COLOR_W      = 24,
   parameter int                 BLINK_FRAMES = 16,
   parameter logic [COLOR_W-1:0] BG_COLOR     = 24'h000000
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             frame_start,
   input  logic [NUM_SPRITES*COLOR_W-1:0]   sprite_rgb,
   input  logic [NUM_SPRITES-1:0]           sprite_vis,
   input  logic [NUM_SPRITES-1:0]           enable_mask,
   input  logic [NUM_SPRITES-1:0]           blink_mask,
   input  logic                             prio_rev,
   output logic                             visible,
   output logic [COLOR_W-1:0]               rgb,
   output logic [$clog2(NUM_SPRITES)-1:0]   hit_id,
   output logic                             collision,
   output logic                             collision_frame,
   output logic                             blink_phase
);

   localparam int ID_W = $clog2(NUM_SPRITES);
   // A single-frame blink period still needs a one-bit counter to exist.
   localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

   // Frame-synchronous control state
   logic [NUM_SPRITES-1:0] r_en_s;
   logic [NUM_SPRITES-1:0] r_bl_s;
   logic                   r_rev_s;
   logic [FC_W-1:0]        r_fc;
   logic                   r_blink_phase;
   logic                   r_coll_live;
   logic                   r_collision_frame;

   // Output register stage
   logic                   r_visible_p1;
   logic [COLOR_W-1:0]     r_rgb_p1;
   logic [ID_W-1:0]        r_hit_id_p1;
   logic                   r_collision_p1;

   // Combinational per-pixel results
   logic [NUM_SPRITES-1:0] w_eff;
   logic                   w_any;
   logic [ID_W-1:0]        w_hit;
   logic [COLOR_W-1:0]     w_rgb;
   logic                   w_seen;
   logic                   w_coll;

   // A sprite counts only if present, enabled and not in its blinked-off half.
   assign w_eff = sprite_vis & r_en_s & ~(r_bl_s & {NUM_SPRITES{r_blink_phase}});

   // Winner select: scan so that the highest-priority hit is assigned last.
   always_comb begin
      w_any = 1'b0;
      w_hit = '0;
      w_rgb = BG_COLOR;
      if (!r_rev_s) begin
         for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (w_eff[i]) begin
               w_any = 1'b1;
               w_hit = ID_W'(i);
               w_rgb = sprite_rgb[i*COLOR_W +: COLOR_W];
            end
         end
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (w_eff[i]) begin
               w_any = 1'b1;
               w_hit = ID_W'(i);
               w_rgb = sprite_rgb[i*COLOR_W +: COLOR_W];
            end
         end
      end
   end

   // Collision detect: a second effective sprite seen means popcount >= 2.
   always_comb begin
      w_seen = 1'b0;
      w_coll = 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (w_eff[i]) begin
            if (w_seen) w_coll = 1'b1;
            w_seen = 1'b1;
         end
      end
   end

   // Output stage: register the composited pixel one clock after its inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_visible_p1   <= 1'b0;
         r_rgb_p1       <= '0;
         r_hit_id_p1    <= '0;
         r_collision_p1 <= 1'b0;
      end else begin
         r_visible_p1   <= w_any;
         r_rgb_p1       <= w_rgb;
         r_hit_id_p1    <= w_hit;
         r_collision_p1 <= w_coll;
      end
   end

   // Shadow controls and blink counter advance only on frame_start.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_en_s        <= '0;
         r_bl_s        <= '0;
         r_rev_s       <= 1'b0;
         r_fc          <= '0;
         r_blink_phase <= 1'b0;
      end else if (frame_start) begin
         r_en_s  <= enable_mask;
         r_bl_s  <= blink_mask;
         r_rev_s <= prio_rev;
         if (r_fc == FC_LAST) begin
            r_fc          <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_fc <= r_fc + 1'b1;
         end
      end
   end

   // Collision history: gather during the frame, publish at frame_start.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_coll_live       <= 1'b0;
         r_collision_frame <= 1'b0;
      end else if (frame_start) begin
         r_collision_frame <= r_coll_live | w_coll;
         r_coll_live       <= 1'b0;
      end else if (w_coll) begin
         r_coll_live <= 1'b1;
      end
   end

   assign visible         = r_visible_p1;
   assign rgb             = r_rgb_p1;
   assign hit_id          = r_hit_id_p1;
   assign collision       = r_collision_p1;
   assign collision_frame = r_collision_frame;
   assign blink_phase     = r_blink_phase;

endmodule

// File: tb/tb_sprite_layer_mux.sv
// Directed bench for sprite_layer_mux: four sprites, 24-bit colour,
// two-frame blink half-period and a non-zero background colour.
module tb_sprite_layer_mux;

   localparam int          NS  = 4;
   localparam int          CW  = 24;
   localparam logic [23:0] BG  = 24'h102030;
   localparam logic [23:0] C0  = 24'hFF0000;
   localparam logic [23:0] C1  = 24'h00FF00;

   logic           clk;
   logic           rst;
   logic           frame_start;
   logic [NS*CW-1:0] sprite_rgb;
   logic [NS-1:0]  sprite_vis;
   logic [NS-1:0]  enable_mask;
   logic [NS-1:0]  blink_mask;
   logic           prio_rev;
   logic           visible;
   logic [CW-1:0]  rgb;
   logic [1:0]     hit_id;
   logic           collision;
   logic           collision_frame;
   logic           blink_phase;

   int vecs = 0;
   int errs = 0;

   sprite_layer_mux #(
      .NUM_SPRITES (NS),
      .COLOR_W     (CW),
      .BLINK_FRAMES(2),
      .BG_COLOR    (BG)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .frame_start    (frame_start),
      .sprite_rgb     (sprite_rgb),
      .sprite_vis     (sprite_vis),
      .enable_mask    (enable_mask),
      .blink_mask     (blink_mask),
      .prio_rev       (prio_rev),
      .visible        (visible),
      .rgb            (rgb),
      .hit_id         (hit_id),
      .collision      (collision),
      .collision_frame(collision_frame),
      .blink_phase    (blink_phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; frame_start = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; frame_start = 1'b1; enable_mask = 4'hF; blink_mask = 4'h0;
      prio_rev = 1'b0; sprite_vis = 4'hF;
      step(); step();
      vecs++; if (visible !== 1'b0) begin errs++; $display("FAIL rst_visible got %b want 0", visible); end
      vecs++; if (rgb !== 24'h0) begin errs++; $display("FAIL rst_rgb got %h want 000000", rgb); end
      vecs++; if (hit_id !== 2'd0) begin errs++; $display("FAIL rst_hit got %0d want 0", hit_id); end
      vecs++; if (collision !== 1'b0) begin errs++; $display("FAIL rst_coll got %b want 0", collision); end
      vecs++; if (collision_frame !== 1'b0) begin errs++; $display("FAIL rst_cframe got %b want 0", collision_frame); end
      vecs++; if (blink_phase !== 1'b0) begin errs++; $display("FAIL rst_phase got %b want 0", blink_phase); end
      rst = 1'b0; frame_start = 1'b0;
      step();
      vecs++; if (visible !== 1'b0) begin errs++; $display("FAIL post_rst_visible got %b want 0", visible); end
      vecs++; if (rgb !== BG) begin errs++; $display("FAIL post_rst_rgb got %h want %h", rgb, BG); end
      vecs++; if (collision !== 1'b0) begin errs++; $display("FAIL post_rst_coll got %b want 0", collision); end
   endtask

   task automatic test_priority();
      do_reset();
      enable_mask = 4'b0011; blink_mask = 4'b0000; prio_rev = 1'b0; sprite_vis = 4'b0000;
      frame_start = 1'b1; step(); frame_start = 1'b0;
      sprite_vis = 4'b0011;
      step();
      vecs++; if (visible !== 1'b1) begin errs++; $display("FAIL prio0_visible got %b want 1", visible); end
      vecs++; if (rgb !== C0) begin errs++; $display("FAIL prio0_rgb got %h want %h", rgb, C0); end
      vecs++; if (hit_id !== 2'd0) begin errs++; $display("FAIL prio0_hit got %0d want 0", hit_id); end
      vecs++; if (collision !== 1'b1) begin errs++; $display("FAIL prio0_coll got %b want 1", collision); end
      prio_rev = 1'b1;
      step();
      vecs++; if (rgb !== C0) begin errs++; $display("FAIL prio_midframe_rgb got %h want %h", rgb, C0); end
      vecs++; if (hit_id !== 2'd0) begin errs++; $display("FAIL prio_midframe_hit got %0d want 0", hit_id); end
      frame_start = 1'b1;
      step();
      vecs++; if (rgb !== C0) begin errs++; $display("FAIL prio_fs_cycle_rgb got %h want %h", rgb, C0); end
      frame_start = 1'b0;
      step();
      vecs++; if (rgb !== C1) begin errs++; $display("FAIL prio1_rgb got %h want %h", rgb, C1); end
      vecs++; if (hit_id !== 2'd1) begin errs++; $display("FAIL prio1_hit got %0d want 1", hit_id); end
      vecs++; if (visible !== 1'b1) begin errs++; $display("FAIL prio1_visible got %b want 1", visible); end
   endtask

   task automatic test_vis_zero();
      sprite_vis = 4'b0000;
      step();
      vecs++; if (visible !== 1'b0) begin errs++; $display("FAIL none_visible got %b want 0", visible); end
      vecs++; if (rgb !== BG) begin errs++; $display("FAIL none_rgb got %h want %h", rgb, BG); end
      vecs++; if (hit_id !== 2'd0) begin errs++; $display("FAIL none_hit got %0d want 0", hit_id); end
      vecs++; if (collision !== 1'b0) begin errs++; $display("FAIL none_coll got %b want 0", collision); end
      sprite_vis = 4'b0010;
      step();
      vecs++; if (rgb !== C1) begin errs++; $display("FAIL lat_on_rgb got %h want %h", rgb, C1); end
      vecs++; if (hit_id !== 2'd1) begin errs++; $display("FAIL lat_on_hit got %0d want 1", hit_id); end
      sprite_vis = 4'b0000;
      #1;
      vecs++; if (rgb !== C1) begin errs++; $display("FAIL lat_hold_rgb got %h want %h", rgb, C1); end
      step();
      vecs++; if (rgb !== BG) begin errs++; $display("FAIL lat_off_rgb got %h want %h", rgb, BG); end
   endtask

   task automatic test_blink();
      do_reset();
      enable_mask = 4'b0011; blink_mask = 4'b0001; prio_rev = 1'b0; sprite_vis = 4'b0011;
      frame_start = 1'b1; step(); frame_start = 1'b0;
      step();
      vecs++; if (rgb !== C0) begin errs++; $display("FAIL blink_f1_rgb got %h want %h", rgb, C0); end
      vecs++; if (blink_phase !== 1'b0) begin errs++; $display("FAIL blink_f1_phase got %b want 0", blink_phase); end
      frame_start = 1'b1; step();
      vecs++; if (rgb !== C0) begin errs++; $display("FAIL blink_f2_edge_rgb got %h want %h", rgb, C0); end
      vecs++; if (blink_phase !== 1'b1) begin errs++; $display("FAIL blink_f2_phase got %b want 1", blink_phase); end
      frame_start = 1'b0; step();
      vecs++; if (rgb !== C1) begin errs++; $display("FAIL blink_hidden_rgb got %h want %h", rgb, C1); end
      vecs++; if (hit_id !== 2'd1) begin errs++; $display("FAIL blink_hidden_hit got %0d want 1", hit_id); end
      vecs++; if (collision !== 1'b0) begin errs++; $display("FAIL blink_hidden_coll got %b want 0", collision); end
      blink_mask = 4'b0011;
      frame_start = 1'b1; step(); frame_start = 1'b0; step();
      vecs++; if (blink_phase !== 1'b1) begin errs++; $display("FAIL blink_f3_phase got %b want 1", blink_phase); end
      vecs++; if (visible !== 1'b0) begin errs++; $display("FAIL blink_all_visible got %b want 0", visible); end
      vecs++; if (rgb !== BG) begin errs++; $display("FAIL blink_all_rgb got %h want %h", rgb, BG); end
      vecs++; if (collision !== 1'b0) begin errs++; $display("FAIL blink_all_coll got %b want 0", collision); end
      blink_mask = 4'b0001;
      frame_start = 1'b1; step(); frame_start = 1'b0; step();
      vecs++; if (blink_phase !== 1'b0) begin errs++; $display("FAIL blink_f4_phase got %b want 0", blink_phase); end
      vecs++; if (rgb !== C0) begin errs++; $display("FAIL blink_f4_rgb got %h want %h", rgb, C0); end
      vecs++; if (collision !== 1'b1) begin errs++; $display("FAIL blink_f4_coll got %b want 1", collision); end
   endtask

   task automatic test_collision_frame();
      do_reset();
      enable_mask = 4'b0111; blink_mask = 4'b0000; prio_rev = 1'b0; sprite_vis = 4'b0000;
      frame_start = 1'b1; step(); frame_start = 1'b0;
      sprite_vis = 4'b0011; step();
      vecs++; if (collision !== 1'b1) begin errs++; $display("FAIL cf_pixel_coll got %b want 1", collision); end
      sprite_vis = 4'b0001; step(); step();
      vecs++; if (collision !== 1'b0) begin errs++; $display("FAIL cf_single_coll got %b want 0", collision); end
      vecs++; if (collision_frame !== 1'b0) begin errs++; $display("FAIL cf_midframe got %b want 0", collision_frame); end
      frame_start = 1'b1; step(); frame_start = 1'b0;
      vecs++; if (collision_frame !== 1'b1) begin errs++; $display("FAIL cf_frameN got %b want 1", collision_frame); end
      step(); step();
      vecs++; if (collision_frame !== 1'b1) begin errs++; $display("FAIL cf_hold got %b want 1", collision_frame); end
      frame_start = 1'b1; step(); frame_start = 1'b0;
      vecs++; if (collision_frame !== 1'b0) begin errs++; $display("FAIL cf_frameN1 got %b want 0", collision_frame); end
      step();
      sprite_vis = 4'b0011; frame_start = 1'b1; step(); frame_start = 1'b0; sprite_vis = 4'b0001;
      vecs++; if (collision_frame !== 1'b1) begin errs++; $display("FAIL cf_fs_cycle got %b want 1", collision_frame); end
      vecs++; if (collision !== 1'b1) begin errs++; $display("FAIL cf_fs_cycle_coll got %b want 1", collision); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      frame_start = 1'b1; step();
      vecs++; if (blink_phase !== 1'b0) begin errs++; $display("FAIL b2b_first got %b want 0", blink_phase); end
      step();
      vecs++; if (blink_phase !== 1'b1) begin errs++; $display("FAIL b2b_second got %b want 1", blink_phase); end
      frame_start = 1'b0; step();
      vecs++; if (blink_phase !== 1'b1) begin errs++; $display("FAIL b2b_hold got %b want 1", blink_phase); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      enable_mask = 4'b0011; blink_mask = 4'b0000; prio_rev = 1'b0; sprite_vis = 4'b0011;
      frame_start = 1'b1; step(); step(); frame_start = 1'b0;
      vecs++; if (blink_phase !== 1'b1) begin errs++; $display("FAIL mr_pre_phase got %b want 1", blink_phase); end
      vecs++; if (collision_frame !== 1'b1) begin errs++; $display("FAIL mr_pre_cframe got %b want 1", collision_frame); end
      step();
      vecs++; if (collision !== 1'b1) begin errs++; $display("FAIL mr_pre_coll got %b want 1", collision); end
      rst = 1'b1; step(); rst = 1'b0;
      vecs++; if (visible !== 1'b0) begin errs++; $display("FAIL mr_visible got %b want 0", visible); end
      vecs++; if (rgb !== 24'h0) begin errs++; $display("FAIL mr_rgb got %h want 000000", rgb); end
      vecs++; if (hit_id !== 2'd0) begin errs++; $display("FAIL mr_hit got %0d want 0", hit_id); end
      vecs++; if (collision !== 1'b0) begin errs++; $display("FAIL mr_coll got %b want 0", collision); end
      vecs++; if (collision_frame !== 1'b0) begin errs++; $display("FAIL mr_cframe got %b want 0", collision_frame); end
      vecs++; if (blink_phase !== 1'b0) begin errs++; $display("FAIL mr_phase got %b want 0", blink_phase); end
      step();
      vecs++; if (rgb !== BG) begin errs++; $display("FAIL mr_bg_rgb got %h want %h", rgb, BG); end
      vecs++; if (collision !== 1'b0) begin errs++; $display("FAIL mr_bg_coll got %b want 0", collision); end
      frame_start = 1'b1; step(); frame_start = 1'b0;
      vecs++; if (collision_frame !== 1'b0) begin errs++; $display("FAIL mr_history got %b want 0", collision_frame); end
      vecs++; if (rgb !== BG) begin errs++; $display("FAIL mr_fs_rgb got %h want %h", rgb, BG); end
      step();
      vecs++; if (rgb !== C0) begin errs++; $display("FAIL mr_resume_rgb got %h want %h", rgb, C0); end
   endtask

   initial begin
      rst = 1'b1; frame_start = 1'b0; sprite_vis = '0; enable_mask = '0;
      blink_mask = '0; prio_rev = 1'b0;
      sprite_rgb = {24'hFFFFFF, 24'h0000FF, C1, C0};
      test_reset();
      test_priority();
      test_vis_zero();
      test_blink();
      test_collision_frame();
      test_back_to_back();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
